// File: rtl/spi_shift_engine_pkg.sv
// Shared constants and state encoding for the SPI character shift engine.
package spi_shift_engine_pkg;

    localparam int SPI_MAX_CHAR      = 32;
    localparam int SPI_CHAR_LEN_BITS = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_shift_engine_bit_index.sv
// Maps a bit ordinal k onto its position inside the character,
// honouring LSB-first or MSB-first ordering.
module spi_bit_index
    import spi_shift_engine_pkg::*;
#(
    parameter int LEN_W = SPI_CHAR_LEN_BITS
) (
    input  logic [LEN_W:0]   k,
    input  logic [LEN_W:0]   len_eff,
    input  logic             lsb,
    output logic [LEN_W-1:0] pos
);

    logic [LEN_W:0] rev_s;

    // k == len_eff only occurs after the last tx bit; the result is unused then
    always_comb begin
        rev_s = len_eff - k - {{LEN_W{1'b0}}, 1'b1};
        if (lsb) begin
            pos = k[LEN_W-1:0];
        end else begin
            pos = rev_s[LEN_W-1:0];
        end
    end

endmodule

// File: rtl/spi_shift_engine.sv
// SPI character shift engine: drives MOSI and samples MISO on clock-gen
// strobes, reporting tip/last_clk upstream and rx_data/done downstream.
module spi_shift_engine
    import spi_shift_engine_pkg::*;
#(
    parameter int MAX_CHAR = SPI_MAX_CHAR,
    parameter int LEN_W    = SPI_CHAR_LEN_BITS
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic                go,
    input  logic [LEN_W-1:0]    len,
    input  logic                lsb,
    input  logic                tx_negedge,
    input  logic                rx_negedge,
    input  logic                pos_edge,
    input  logic                neg_edge,
    input  logic [MAX_CHAR-1:0] tx_data,
    input  logic                miso,
    output logic                tip,
    output logic                last_clk,
    output logic                mosi,
    output logic [MAX_CHAR-1:0] rx_data,
    output logic                done
);

    localparam int             CNT_W   = LEN_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CHAR);

    spi_state_t          state_r;
    logic [MAX_CHAR-1:0] tx_word_r;
    logic [CNT_W-1:0]    len_eff_r;
    logic                lsb_r;
    logic                tx_neg_r;
    logic                rx_neg_r;
    logic [CNT_W-1:0]    tx_cnt_r;
    logic [CNT_W-1:0]    rx_cnt_r;
    logic                mosi_r;
    logic                tip_r;
    logic                done_r;
    logic [MAX_CHAR-1:0] rx_data_r;

    logic [CNT_W-1:0]    len_in_s;
    logic [CNT_W-1:0]    load_last_s;
    logic [LEN_W-1:0]    load_pos_s;
    logic [CNT_W-1:0]    rx_cnt_nxt_s;
    logic                tx_edge_s;
    logic                rx_edge_s;
    logic [LEN_W-1:0]    tx_pos_s;
    logic [LEN_W-1:0]    rx_pos_s;

    // Effective length of the requested character and the first bit to drive
    always_comb begin
        if (len == {LEN_W{1'b0}}) begin
            len_in_s = CNT_MAX;
        end else begin
            len_in_s = {1'b0, len};
        end
        load_last_s = len_in_s - CNT_ONE;
        if (lsb) begin
            load_pos_s = {LEN_W{1'b0}};
        end else begin
            load_pos_s = load_last_s[LEN_W-1:0];
        end
    end

    // Edge selection uses the configuration latched at load
    always_comb begin
        if (tx_neg_r) begin
            tx_edge_s = neg_edge;
        end else begin
            tx_edge_s = pos_edge;
        end
        if (rx_neg_r) begin
            rx_edge_s = neg_edge;
        end else begin
            rx_edge_s = pos_edge;
        end
        rx_cnt_nxt_s = rx_cnt_r + CNT_ONE;
    end

    spi_bit_index #(.LEN_W(LEN_W)) u_tx_index (
        .k       (tx_cnt_r),
        .len_eff (len_eff_r),
        .lsb     (lsb_r),
        .pos     (tx_pos_s)
    );

    spi_bit_index #(.LEN_W(LEN_W)) u_rx_index (
        .k       (rx_cnt_r),
        .len_eff (len_eff_r),
        .lsb     (lsb_r),
        .pos     (rx_pos_s)
    );

    // Character sequencer: load, shift on strobes, single-cycle completion
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            tx_word_r <= {MAX_CHAR{1'b0}};
            len_eff_r <= {CNT_W{1'b0}};
            lsb_r     <= 1'b0;
            tx_neg_r  <= 1'b0;
            rx_neg_r  <= 1'b0;
            tx_cnt_r  <= {CNT_W{1'b0}};
            rx_cnt_r  <= {CNT_W{1'b0}};
            mosi_r    <= 1'b0;
            tip_r     <= 1'b0;
            done_r    <= 1'b0;
            rx_data_r <= {MAX_CHAR{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    tip_r  <= 1'b0;
                    done_r <= 1'b0;
                    if (go) begin
                        state_r   <= ST_SHIFT;
                        tip_r     <= 1'b1;
                        tx_word_r <= tx_data;
                        len_eff_r <= len_in_s;
                        lsb_r     <= lsb;
                        tx_neg_r  <= tx_negedge;
                        rx_neg_r  <= rx_negedge;
                        mosi_r    <= tx_data[load_pos_s];
                        tx_cnt_r  <= CNT_ONE;
                        rx_cnt_r  <= {CNT_W{1'b0}};
                        rx_data_r <= {MAX_CHAR{1'b0}};
                    end
                end
                ST_SHIFT: begin
                    // Sampling uses the pre-edge miso while mosi advances in parallel
                    if (tx_edge_s && (tx_cnt_r < len_eff_r)) begin
                        mosi_r   <= tx_word_r[tx_pos_s];
                        tx_cnt_r <= tx_cnt_r + CNT_ONE;
                    end
                    if (rx_edge_s) begin
                        rx_data_r[rx_pos_s] <= miso;
                        rx_cnt_r            <= rx_cnt_nxt_s;
                        if (rx_cnt_nxt_s == len_eff_r) begin
                            state_r <= ST_DONE;
                            tip_r   <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    tip_r   <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    tip_r   <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign tip      = tip_r;
    assign done     = done_r;
    assign mosi     = mosi_r;
    assign rx_data  = rx_data_r;
    assign last_clk = (state_r == ST_SHIFT) && (rx_cnt_r == (len_eff_r - CNT_ONE));

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: directed characters plus randomized ones,
// each cycle compared with a bit-list model of the character transfer.
module tb_spi_shift_engine;

    logic        clk_in = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic [4:0]  len = 5'd0;
    logic        lsb = 1'b0;
    logic        tx_negedge = 1'b0;
    logic        rx_negedge = 1'b0;
    logic        pos_edge = 1'b0;
    logic        neg_edge = 1'b0;
    logic [31:0] tx_data = 32'd0;
    logic        miso;
    logic        tip;
    logic        last_clk;
    logic        mosi;
    logic [31:0] rx_data;
    logic        done;

    logic        loop_mode = 1'b1;
    logic        ext_bit = 1'b0;
    logic [31:0] ext_word = 32'd0;

    assign miso = loop_mode ? mosi : ext_bit;

    always #5 clk_in = ~clk_in;

    spi_shift_engine dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .go         (go),
        .len        (len),
        .lsb        (lsb),
        .tx_negedge (tx_negedge),
        .rx_negedge (rx_negedge),
        .pos_edge   (pos_edge),
        .neg_edge   (neg_edge),
        .tx_data    (tx_data),
        .miso       (miso),
        .tip        (tip),
        .last_clk   (last_clk),
        .mosi       (mosi),
        .rx_data    (rx_data),
        .done       (done)
    );

    // reference model of one character: bits sent so far, bits received so far
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    bit          m_mosi = 1'b0;
    bit          m_lsb = 1'b0;
    bit          m_txn = 1'b0;
    bit          m_rxn = 1'b0;
    logic [31:0] m_rx = 32'd0;
    logic [31:0] m_word = 32'd0;
    int          m_len = 0;
    int          m_sent = 0;
    int          m_got = 0;

    int          tests = 0;
    int          fails = 0;
    int          done_cnt = 0;
    int          cg_cnt = 0;
    bit          cg_sclk = 1'b0;
    int          divider = 1;
    bit          rand_strobes = 1'b0;
    bit          hold_go = 1'b0;
    bit          scramble = 1'b0;

    function automatic int mpos(input int k);
        return m_lsb ? k : m_len - 1 - k;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic p, n, smp, te, re;
        @(negedge clk_in);
        if (rand_strobes) begin
            p = ($urandom_range(0, 2) == 0);
            n = ($urandom_range(0, 2) == 0);
        end else if (m_busy) begin
            if (cg_cnt == divider) begin
                cg_cnt  = 0;
                cg_sclk = !cg_sclk;
                p = cg_sclk;
                n = !cg_sclk;
            end else begin
                cg_cnt++;
                p = 1'b0;
                n = 1'b0;
            end
        end else begin
            cg_cnt  = 0;
            cg_sclk = 1'b0;
            p = 1'b0;
            n = 1'b0;
        end
        pos_edge = p;
        neg_edge = n;
        ext_bit  = (m_busy && m_got < m_len) ? ext_word[mpos(m_got)] : 1'b0;
        smp = loop_mode ? m_mosi : ext_bit;
        te  = m_txn ? n : p;
        re  = m_rxn ? n : p;
        if (m_busy) begin
            if (re) begin
                m_rx[mpos(m_got)] = smp;
                m_got++;
                if (m_got == m_len) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
            if (te && m_sent < m_len) begin
                m_mosi = m_word[mpos(m_sent)];
                m_sent++;
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (go) begin
            m_len  = (len == 5'd0) ? 32 : int'(len);
            m_lsb  = lsb;
            m_txn  = tx_negedge;
            m_rxn  = rx_negedge;
            m_word = tx_data;
            m_rx   = 32'd0;
            m_got  = 0;
            m_mosi = m_word[mpos(0)];
            m_sent = 1;
            m_busy = 1'b1;
        end
        @(posedge clk_in);
        #1;
        if (done) done_cnt++;
        check("tip", {31'd0, tip}, {31'd0, m_busy});
        check("done", {31'd0, done}, {31'd0, m_done});
        check("mosi", {31'd0, mosi}, {31'd0, m_mosi});
        check("last_clk", {31'd0, last_clk}, {31'd0, (m_busy && m_got == m_len - 1)});
        check("rx_data", rx_data, m_rx);
    endtask

    task automatic setup(input logic [4:0] l, input bit b_lsb, input bit txn, input bit rxn,
                         input logic [31:0] data, input bit lp, input logic [31:0] ext,
                         input bit rs, input int div);
        len = l; lsb = b_lsb; tx_negedge = txn; rx_negedge = rxn; tx_data = data;
        loop_mode = lp; ext_word = ext; rand_strobes = rs; divider = div;
    endtask

    task automatic start();
        go = 1'b1;
        tick();
        if (!hold_go) go = 1'b0;
    endtask

    task automatic finish(input int budget);
        int n = 0;
        while ((m_busy || m_done) && n < budget) begin
            if (scramble) begin
                len = 5'($urandom); lsb = 1'($urandom); tx_negedge = 1'($urandom);
                rx_negedge = 1'($urandom); tx_data = $urandom;
            end
            tick();
            n++;
        end
        check("char_within_budget", {31'd0, (n < budget)}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // power-on reset
        repeat (3) @(negedge clk_in);
        check("rst_tip", {31'd0, tip}, 32'd0);
        check("rst_last_clk", {31'd0, last_clk}, 32'd0);
        check("rst_mosi", {31'd0, mosi}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rx_data", rx_data, 32'd0);
        rst_n = 1'b1;
        tick();

        // MSB-first 0xA5, tx on neg, rx on pos, loopback
        done_cnt = 0;
        setup(5'd8, 1'b0, 1'b1, 1'b0, 32'h0000_00A5, 1'b1, 32'd0, 1'b0, 1);
        start();
        finish(200);
        check("a5_rx", rx_data, 32'h0000_00A5);
        check("a5_done_once", done_cnt, 32'd1);

        // LSB-first, 32 bits, external MISO pattern
        setup(5'd0, 1'b1, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF, 1'b0, 1);
        start();
        finish(400);
        check("len32_rx", rx_data, 32'hDEAD_BEEF);

        // single-bit character, strobes every cycle
        done_cnt = 0;
        setup(5'd1, 1'b0, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 32'd0, 1'b0, 0);
        start();
        check("len1_last_clk_at_load", {31'd0, last_clk}, 32'd1);
        check("len1_mosi", {31'd0, mosi}, 32'd1);
        finish(20);
        check("len1_done_once", done_cnt, 32'd1);

        // tx and rx on the same edge, loopback
        setup(5'd4, 1'b0, 1'b1, 1'b1, 32'h0000_0009, 1'b1, 32'd0, 1'b0, 1);
        start();
        finish(100);

        // go held high across three characters
        done_cnt = 0;
        hold_go = 1'b1;
        setup(5'd8, 1'b1, 1'b0, 1'b1, 32'h0000_003C, 1'b1, 32'd0, 1'b0, 0);
        for (int c = 0; c < 3; c++) begin
            start();
            finish(100);
        end
        go = 1'b0;
        hold_go = 1'b0;
        check("held_go_done_count", done_cnt, 32'd3);

        // randomized characters with stray strobes and mid-transfer input churn
        for (int c = 0; c < 25; c++) begin
            setup(5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom,
                  1'($urandom), $urandom, 1'($urandom), $urandom_range(0, 2));
            scramble = 1'b1;
            start();
            finish(2000);
            scramble = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end

        // asynchronous reset after three received bits
        setup(5'd8, 1'b0, 1'b1, 1'b0, 32'h0000_00C3, 1'b1, 32'd0, 1'b0, 1);
        start();
        for (int n = 0; n < 100 && m_got < 3; n++) tick();
        check("pre_reset_three_bits", m_got, 32'd3);
        @(negedge clk_in);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_tip", {31'd0, tip}, 32'd0);
        check("mid_rst_last_clk", {31'd0, last_clk}, 32'd0);
        check("mid_rst_mosi", {31'd0, mosi}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_rx_data", rx_data, 32'd0);
        m_busy = 1'b0; m_done = 1'b0; m_mosi = 1'b0; m_rx = 32'd0;
        m_got = 0; m_sent = 0; cg_cnt = 0; cg_sclk = 1'b0;
        pos_edge = 1'b0; neg_edge = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        tick();
        setup(5'd8, 1'b0, 1'b1, 1'b0, 32'h0000_0096, 1'b1, 32'd0, 1'b0, 1);
        start();
        finish(200);
        check("post_reset_rx", rx_data, 32'h0000_0096);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
